// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush, sticky overflow/underflow flags and a
// choice between first-word-fall-through and registered read data.
module sync_fifo_flags #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter bit FWFT               = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_increment,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     read_increment,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  // Thresholds carried at count width so every flag is a same-width compare.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_C    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] AE_C    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] write_ptr;
  logic [ADDRESS_WIDTH-1:0] read_ptr;
  logic [ADDRESS_WIDTH:0]   count_q;
  logic                     write_accept;
  logic                     read_accept;

  // Flags decode the registered count only, so they trail the causing edge.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // Full/empty gate the requests; there is no write-through or read-through.
  assign write_accept = write_increment && !full;
  assign read_accept  = read_increment && !empty;

  // Pointers and occupancy; flush empties the FIFO and swallows requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count_q   <= '0;
    end else if (flush) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count_q   <= '0;
    end else begin
      if (write_accept) write_ptr <= write_ptr + ADDRESS_WIDTH'(1);
      if (read_accept)  read_ptr  <= read_ptr + ADDRESS_WIDTH'(1);
      case ({write_accept, read_accept})
        2'b10:   count_q <= count_q + (ADDRESS_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDRESS_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, and a flushed cycle cannot set them.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (write_increment && full) overflow  <= 1'b1;
      if (read_increment && empty) underflow <= 1'b1;
    end
  end

  // Storage array; contents survive reset and flush, only pointers move.
  always_ff @(posedge clock) begin
    if (!reset && !flush && write_accept) mem[write_ptr] <= write_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally whenever the FIFO holds data.
      assign read_data = mem[read_ptr];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] read_data_q;

      // Popped word is captured at the accepting edge and held until the next pop.
      always_ff @(posedge clock) begin
        if (reset) begin
          read_data_q <= '0;
        end else if (!flush && read_accept) begin
          read_data_q <= mem[read_ptr];
        end
      end

      assign read_data = read_data_q;
    end
  endgenerate

endmodule
